membus_arb: RTL and testbench

- Two-master arbiter for one core memory port.
- Lets the KA10 processor (master A) and a second membus master (master B, e.g. a data channel) share port p0 of core161c.
- Grants the port for exactly one complete memory cycle (read, write or read-modify-write) at a time.
- Routes memory responses only to the owning master; times out unanswered cycles and flags non-existent memory (NXM).

---
 rtl/membus_arb_pkg.sv | 18 +
 rtl/membus_arb_if.sv | 42 ++++
 rtl/membus_nxm_timer.sv | 41 ++++
 rtl/membus_arb.sv | 166 ++++++++++++++++
 tb/tb_membus_arb.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/membus_arb_pkg.sv
// rtl/membus_arb_pkg.sv - shared types and widths for the two-master membus arbiter
package membus_arb_pkg;
    localparam int MA_W   = 18;
    localparam int WORD_W = 36;
    localparam int TMR_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_REL  = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_e;
endpackage

// File: rtl/membus_arb_if.sv
// rtl/membus_arb_if.sv - bundle of master A, master B and memory-port membus signals
interface membus_arb_if;
    import membus_arb_pkg::*;

    logic              a_rq_cyc, a_rd_rq, a_wr_rq, a_wr_rs, a_fmc_select;
    logic [MA_W-1:0]   a_ma;
    logic [WORD_W-1:0] a_mb_out;
    logic              a_addr_ack, a_rd_rs, a_nxm;
    logic [WORD_W-1:0] a_mb_in;

    logic              b_rq_cyc, b_rd_rq, b_wr_rq, b_wr_rs, b_fmc_select;
    logic [MA_W-1:0]   b_ma;
    logic [WORD_W-1:0] b_mb_out;
    logic              b_addr_ack, b_rd_rs, b_nxm;
    logic [WORD_W-1:0] b_mb_in;

    logic              m_rq_cyc, m_rd_rq, m_wr_rq, m_wr_rs, m_fmc_select;
    logic [MA_W-1:0]   m_ma;
    logic [WORD_W-1:0] m_mb_out;
    logic              m_addr_ack, m_rd_rs;
    logic [WORD_W-1:0] m_mb_in;

    // Arbiter side
    modport slave (
        input  a_rq_cyc, a_rd_rq, a_wr_rq, a_wr_rs, a_fmc_select, a_ma, a_mb_out,
        output a_addr_ack, a_rd_rs, a_nxm, a_mb_in,
        input  b_rq_cyc, b_rd_rq, b_wr_rq, b_wr_rs, b_fmc_select, b_ma, b_mb_out,
        output b_addr_ack, b_rd_rs, b_nxm, b_mb_in,
        output m_rq_cyc, m_rd_rq, m_wr_rq, m_wr_rs, m_fmc_select, m_ma, m_mb_out,
        input  m_addr_ack, m_rd_rs, m_mb_in
    );

    // Masters and memory side
    modport master (
        output a_rq_cyc, a_rd_rq, a_wr_rq, a_wr_rs, a_fmc_select, a_ma, a_mb_out,
        input  a_addr_ack, a_rd_rs, a_nxm, a_mb_in,
        output b_rq_cyc, b_rd_rq, b_wr_rq, b_wr_rs, b_fmc_select, b_ma, b_mb_out,
        input  b_addr_ack, b_rd_rs, b_nxm, b_mb_in,
        input  m_rq_cyc, m_rd_rq, m_wr_rq, m_wr_rs, m_fmc_select, m_ma, m_mb_out,
        output m_addr_ack, m_rd_rs, m_mb_in
    );
endinterface

// File: rtl/membus_nxm_timer.sv
// rtl/membus_nxm_timer.sv - grant-to-address-ack watchdog; expire is high while the count sits at zero
module membus_nxm_timer
    import membus_arb_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic stop,
    output logic expire
);
    logic [TMR_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;

    assign expire = run_q && (cnt_q == '0);

    // Load wins over stop so a grant edge always re-arms the watchdog
    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (load) begin
            cnt_d = TMR_W'(TIMEOUT);
            run_d = 1'b1;
        end else if (stop || expire) begin
            run_d = 1'b0;
        end else if (run_q) begin
            cnt_d = cnt_q - TMR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end
endmodule

// File: rtl/membus_arb.sv
// rtl/membus_arb.sv - grants core port p0 to master A or B for one whole memory cycle
module membus_arb
    import membus_arb_pkg::*;
#(
    parameter int PRIO_MODE = 1,
    parameter int TIMEOUT   = 64
) (
    input  logic         clk,
    input  logic         reset,
    membus_arb_if.slave  bus
);
    arb_state_e state_q, state_d;
    owner_e     owner_q, owner_d, last_q, last_d;
    logic       rd_pend_q, rd_pend_d, wr_pend_q, wr_pend_d, acked_q, acked_d;
    logic       rearm_a_q, rearm_a_d, rearm_b_q, rearm_b_d;
    logic       own_a, own_b, elig_a, elig_b, grant_a, grant_b;
    logic       tmr_load, tmr_stop, tmr_expire, nxm;

    logic              o_rq_cyc, o_rd_rq, o_wr_rq, o_wr_rs, o_fmc;
    logic [MA_W-1:0]   o_ma;
    logic [WORD_W-1:0] o_mb_out;

    assign own_a = (state_q == ST_OWN) && (owner_q == OWN_A);
    assign own_b = (state_q == ST_OWN) && (owner_q == OWN_B);

    always_comb begin
        o_rq_cyc = 1'b0;
        o_rd_rq  = 1'b0;
        o_wr_rq  = 1'b0;
        o_wr_rs  = 1'b0;
        o_fmc    = 1'b0;
        o_ma     = '0;
        o_mb_out = '0;
        if (own_a) begin
            o_rq_cyc = bus.a_rq_cyc;
            o_rd_rq  = bus.a_rd_rq;
            o_wr_rq  = bus.a_wr_rq;
            o_wr_rs  = bus.a_wr_rs;
            o_fmc    = bus.a_fmc_select;
            o_ma     = bus.a_ma;
            o_mb_out = bus.a_mb_out;
        end else if (own_b) begin
            o_rq_cyc = bus.b_rq_cyc;
            o_rd_rq  = bus.b_rd_rq;
            o_wr_rq  = bus.b_wr_rq;
            o_wr_rs  = bus.b_wr_rs;
            o_fmc    = bus.b_fmc_select;
            o_ma     = bus.b_ma;
            o_mb_out = bus.b_mb_out;
        end
    end

    assign bus.m_rq_cyc     = o_rq_cyc;
    assign bus.m_rd_rq      = o_rd_rq;
    assign bus.m_wr_rq      = o_wr_rq;
    assign bus.m_wr_rs      = o_wr_rs;
    assign bus.m_fmc_select = o_fmc;
    assign bus.m_ma         = o_ma;
    assign bus.m_mb_out     = o_mb_out;

    assign bus.a_addr_ack = own_a & bus.m_addr_ack;
    assign bus.a_rd_rs    = own_a & bus.m_rd_rs;
    assign bus.a_mb_in    = own_a ? bus.m_mb_in : '0;
    assign bus.a_nxm      = own_a & nxm;
    assign bus.b_addr_ack = own_b & bus.m_addr_ack;
    assign bus.b_rd_rs    = own_b & bus.m_rd_rs;
    assign bus.b_mb_in    = own_b ? bus.m_mb_in : '0;
    assign bus.b_nxm      = own_b & nxm;

    // A request held across NXM or abort stays ineligible until rq_cyc drops
    assign elig_a = bus.a_rq_cyc & rearm_a_q;
    assign elig_b = bus.b_rq_cyc & rearm_b_q;

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (elig_a && elig_b) begin
            if (PRIO_MODE == 0 || last_q == OWN_B) grant_a = 1'b1;
            else                                   grant_b = 1'b1;
        end else begin
            grant_a = elig_a;
            grant_b = elig_b;
        end
    end

    assign tmr_stop = (state_q != ST_OWN) || bus.m_addr_ack;

    membus_nxm_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .rst_n  (reset),
        .load   (tmr_load),
        .stop   (tmr_stop),
        .expire (tmr_expire)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        rd_pend_d = rd_pend_q;
        wr_pend_d = wr_pend_q;
        acked_d   = acked_q;
        rearm_a_d = rearm_a_q | ~bus.a_rq_cyc;
        rearm_b_d = rearm_b_q | ~bus.b_rq_cyc;
        tmr_load  = 1'b0;
        nxm       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_a || grant_b) begin
                    state_d   = ST_OWN;
                    owner_d   = grant_a ? OWN_A : OWN_B;
                    rd_pend_d = grant_a ? bus.a_rd_rq : bus.b_rd_rq;
                    wr_pend_d = grant_a ? bus.a_wr_rq : bus.b_wr_rq;
                    acked_d   = 1'b0;
                    tmr_load  = 1'b1;
                    if (grant_a) rearm_a_d = 1'b0;
                    else         rearm_b_d = 1'b0;
                end
            end
            ST_OWN: begin
                if (bus.m_addr_ack)      acked_d   = 1'b1;
                if (bus.m_rd_rs)         rd_pend_d = 1'b0;
                if (o_wr_rs && acked_q)  wr_pend_d = 1'b0;
                if (!o_rq_cyc) begin
                    state_d = ST_REL;
                end else if (tmr_expire && !bus.m_addr_ack) begin
                    nxm     = 1'b1;
                    state_d = ST_REL;
                end else if (acked_d && !rd_pend_d && !wr_pend_d) begin
                    state_d = ST_REL;
                end
            end
            ST_REL: begin
                last_d  = owner_q;
                owner_d = OWN_NONE;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_NONE;
            last_q    <= OWN_B;
            rd_pend_q <= 1'b0;
            wr_pend_q <= 1'b0;
            acked_q   <= 1'b0;
            rearm_a_q <= 1'b1;
            rearm_b_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            rd_pend_q <= rd_pend_d;
            wr_pend_q <= wr_pend_d;
            acked_q   <= acked_d;
            rearm_a_q <= rearm_a_d;
            rearm_b_q <= rearm_b_d;
        end
    end
endmodule

// File: tb/tb_membus_arb.sv
// tb/tb_membus_arb.sv - directed bench for membus_arb, round-robin and fixed-priority instances
module tb_membus_arb;
    import membus_arb_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    membus_arb_if bus1 ();
    membus_arb_if bus0 ();

    membus_arb #(.PRIO_MODE(1), .TIMEOUT(16)) u_rr (.clk(clk), .reset(reset), .bus(bus1));
    membus_arb #(.PRIO_MODE(0), .TIMEOUT(16)) u_fx (.clk(clk), .reset(reset), .bus(bus0));

    always #5 clk = ~clk;

    // Fixed-priority instance mirrors every input of the round-robin one
    assign bus0.a_rq_cyc = bus1.a_rq_cyc;  assign bus0.a_rd_rq = bus1.a_rd_rq;
    assign bus0.a_wr_rq  = bus1.a_wr_rq;   assign bus0.a_wr_rs = bus1.a_wr_rs;
    assign bus0.a_fmc_select = bus1.a_fmc_select;
    assign bus0.a_ma     = bus1.a_ma;      assign bus0.a_mb_out = bus1.a_mb_out;
    assign bus0.b_rq_cyc = bus1.b_rq_cyc;  assign bus0.b_rd_rq = bus1.b_rd_rq;
    assign bus0.b_wr_rq  = bus1.b_wr_rq;   assign bus0.b_wr_rs = bus1.b_wr_rs;
    assign bus0.b_fmc_select = bus1.b_fmc_select;
    assign bus0.b_ma     = bus1.b_ma;      assign bus0.b_mb_out = bus1.b_mb_out;
    assign bus0.m_addr_ack = bus1.m_addr_ack;
    assign bus0.m_rd_rs  = bus1.m_rd_rs;   assign bus0.m_mb_in = bus1.m_mb_in;

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [MA_W-1:0] obs, input logic [MA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [WORD_W-1:0] obs, input logic [WORD_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        bus1.a_rq_cyc = 1'b0; bus1.a_rd_rq = 1'b0; bus1.a_wr_rq = 1'b0; bus1.a_wr_rs = 1'b0;
        bus1.a_fmc_select = 1'b0; bus1.a_ma = '0; bus1.a_mb_out = '0;
        bus1.b_rq_cyc = 1'b0; bus1.b_rd_rq = 1'b0; bus1.b_wr_rq = 1'b0; bus1.b_wr_rs = 1'b0;
        bus1.b_fmc_select = 1'b0; bus1.b_ma = '0; bus1.b_mb_out = '0;
        bus1.m_addr_ack = 1'b0; bus1.m_rd_rs = 1'b0; bus1.m_mb_in = '0;
    endtask

    initial begin
        reset = 1'b0;
        clear_all();
        repeat (2) step();
        bus1.a_rq_cyc = 1'b1; bus1.m_addr_ack = 1'b1; bus1.m_mb_in = '1;
        #1;
        chk_b("rst_m_rq_cyc", bus1.m_rq_cyc, 1'b0);
        chk_b("rst_a_addr_ack", bus1.a_addr_ack, 1'b0);
        chk_w("rst_a_mb_in", bus1.a_mb_in, '0);
        clear_all();
        step();
        reset = 1'b1;
        step();

        // Both masters contend every round, dropping rq_cyc for one cycle after each cycle
        for (int r = 0; r < 4; r++) begin
            bus1.a_rq_cyc = 1'b1; bus1.a_rd_rq = 1'b1; bus1.a_ma = 18'o100;
            bus1.b_rq_cyc = 1'b1; bus1.b_rd_rq = 1'b1; bus1.b_ma = 18'o200;
            #1;
            chk_b("alt_pre_grant", bus1.m_rq_cyc, 1'b0);
            step();
            chk_a("alt_rr_ma", bus1.m_ma, (r % 2 == 0) ? 18'o100 : 18'o200);
            chk_a("alt_fx_ma", bus0.m_ma, 18'o100);
            bus1.m_addr_ack = 1'b1; bus1.m_rd_rs = 1'b1; bus1.m_mb_in = 36'(r + 1);
            #1;
            chk_b("alt_rr_a_rd_rs", bus1.a_rd_rs, (r % 2 == 0));
            chk_w("alt_rr_b_mb_in", bus1.b_mb_in, (r % 2 == 0) ? 36'd0 : 36'(r + 1));
            step();
            bus1.m_addr_ack = 1'b0; bus1.m_rd_rs = 1'b0; bus1.m_mb_in = '0;
            bus1.a_rq_cyc = 1'b0; bus1.b_rq_cyc = 1'b0;
            #1;
            chk_b("alt_rel", bus1.m_rq_cyc, 1'b0);
            step();
        end
        bus1.b_rd_rq = 1'b0;

        // Single read by A
        bus1.a_rq_cyc = 1'b1; bus1.a_rd_rq = 1'b1; bus1.a_ma = 18'o20;
        #1;
        chk_b("rd_pre_grant", bus1.m_rq_cyc, 1'b0);
        step();
        chk_b("rd_grant", bus1.m_rq_cyc, 1'b1);
        chk_a("rd_ma", bus1.m_ma, 18'o20);
        chk_b("rd_m_rd_rq", bus1.m_rd_rq, 1'b1);
        step(); step();
        bus1.m_addr_ack = 1'b1;
        #1;
        chk_b("rd_a_ack", bus1.a_addr_ack, 1'b1);
        chk_b("rd_b_ack", bus1.b_addr_ack, 1'b0);
        step();
        bus1.m_addr_ack = 1'b0;
        step(); step();
        bus1.m_rd_rs = 1'b1; bus1.m_mb_in = 36'o200121000001;
        #1;
        chk_w("rd_a_mb_in", bus1.a_mb_in, 36'o200121000001);
        chk_w("rd_b_mb_in", bus1.b_mb_in, '0);
        chk_b("rd_held", bus1.m_rq_cyc, 1'b1);
        step();
        bus1.m_rd_rs = 1'b0; bus1.a_rq_cyc = 1'b0; bus1.a_rd_rq = 1'b0;
        #1;
        chk_b("rd_rel", bus1.m_rq_cyc, 1'b0);
        chk_w("rd_mb_gated_rel", bus1.a_mb_in, '0);
        step();
        bus1.m_mb_in = '0;

        // Read-modify-write by B while A waits
        bus1.b_rq_cyc = 1'b1; bus1.b_rd_rq = 1'b1; bus1.b_wr_rq = 1'b1;
        bus1.b_ma = 18'o300; bus1.b_mb_out = 36'o777777777777;
        step();
        bus1.a_rq_cyc = 1'b1; bus1.a_rd_rq = 1'b1; bus1.a_ma = 18'o20;
        bus1.b_wr_rs = 1'b1;
        #1;
        chk_a("rmw_ma", bus1.m_ma, 18'o300);
        chk_w("rmw_mb_out", bus1.m_mb_out, 36'o777777777777);
        chk_b("rmw_wr_rq", bus1.m_wr_rq, 1'b1);
        step();
        bus1.b_wr_rs = 1'b0; bus1.m_addr_ack = 1'b1;
        #1;
        chk_b("rmw_b_ack", bus1.b_addr_ack, 1'b1);
        chk_b("rmw_a_ack", bus1.a_addr_ack, 1'b0);
        step();
        bus1.m_addr_ack = 1'b0; bus1.m_rd_rs = 1'b1; bus1.m_mb_in = 36'o123;
        #1;
        chk_w("rmw_b_mb_in", bus1.b_mb_in, 36'o123);
        step();
        bus1.m_rd_rs = 1'b0; bus1.m_mb_in = '0;
        #1;
        chk_b("rmw_hold", bus1.m_rq_cyc, 1'b1);
        chk_a("rmw_hold_ma", bus1.m_ma, 18'o300);
        step();
        bus1.b_wr_rs = 1'b1;
        #1;
        chk_b("rmw_m_wr_rs", bus1.m_wr_rs, 1'b1);
        step();
        bus1.b_wr_rs = 1'b0; bus1.b_rq_cyc = 1'b0; bus1.b_rd_rq = 1'b0; bus1.b_wr_rq = 1'b0;
        #1;
        chk_b("rmw_rel", bus1.m_rq_cyc, 1'b0);
        step();
        chk_b("rmw_idle", bus1.m_rq_cyc, 1'b0);
        step();
        chk_b("rmw_a_grant", bus1.m_rq_cyc, 1'b1);
        chk_a("rmw_a_ma", bus1.m_ma, 18'o20);

        // A aborts one cycle after grant, B takes the port next
        step();
        bus1.a_rq_cyc = 1'b0; bus1.a_rd_rq = 1'b0;
        bus1.b_rq_cyc = 1'b1; bus1.b_rd_rq = 1'b1; bus1.b_ma = 18'o400;
        #1;
        chk_b("abt_nxm", bus1.a_nxm, 1'b0);
        step();
        chk_b("abt_rel", bus1.m_rq_cyc, 1'b0);
        chk_b("abt_rel_nxm", bus1.a_nxm, 1'b0);
        step();
        step();
        chk_b("abt_b_grant", bus1.m_rq_cyc, 1'b1);
        chk_a("abt_b_ma", bus1.m_ma, 18'o400);
        bus1.m_addr_ack = 1'b1; bus1.m_rd_rs = 1'b1;
        step();
        bus1.m_addr_ack = 1'b0; bus1.m_rd_rs = 1'b0; bus1.b_rq_cyc = 1'b0; bus1.b_rd_rq = 1'b0;
        step();

        // Non-existent memory: no ack ever arrives
        bus1.a_rq_cyc = 1'b1; bus1.a_rd_rq = 1'b1; bus1.a_ma = 18'o40000;
        step();
        chk_a("nxm_ma", bus1.m_ma, 18'o40000);
        repeat (15) step();
        chk_b("nxm_early", bus1.a_nxm, 1'b0);
        step();
        chk_b("nxm_pulse", bus1.a_nxm, 1'b1);
        chk_b("nxm_b_quiet", bus1.b_nxm, 1'b0);
        step();
        chk_b("nxm_end", bus1.a_nxm, 1'b0);
        chk_b("nxm_rel", bus1.m_rq_cyc, 1'b0);
        repeat (4) step();
        chk_b("nxm_no_regrant", bus1.m_rq_cyc, 1'b0);
        bus1.a_rq_cyc = 1'b0;
        step();
        bus1.a_rq_cyc = 1'b1;
        step();
        chk_b("nxm_regrant", bus1.m_rq_cyc, 1'b1);

        // Asynchronous reset in the middle of a read
        step();
        bus1.m_addr_ack = 1'b1;
        step();
        bus1.m_addr_ack = 1'b0; bus1.m_rd_rs = 1'b1; bus1.m_mb_in = 36'o555;
        reset = 1'b0;
        #1;
        chk_b("arst_m_rq_cyc", bus1.m_rq_cyc, 1'b0);
        chk_a("arst_m_ma", bus1.m_ma, '0);
        chk_b("arst_a_rd_rs", bus1.a_rd_rs, 1'b0);
        chk_w("arst_a_mb_in", bus1.a_mb_in, '0);
        bus1.m_rd_rs = 1'b0; bus1.m_mb_in = '0; bus1.a_rq_cyc = 1'b0;
        step();
        reset = 1'b1;
        bus1.a_rq_cyc = 1'b1; bus1.a_rd_rq = 1'b1;
        bus1.b_rq_cyc = 1'b1; bus1.b_rd_rq = 1'b1; bus1.b_ma = 18'o400;
        #1;
        chk_b("arst_pre_grant", bus1.m_rq_cyc, 1'b0);
        step();
        chk_b("arst_grant", bus1.m_rq_cyc, 1'b1);
        chk_a("arst_tie_a", bus1.m_ma, 18'o40000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
